// File: rtl/spm_boot_pkg.sv
`default_nettype none
// ============================================================================
// Package : spm_boot_pkg
// Purpose : Shared constants and state encoding for the RISC_SPM boot loader.
//           Defines the default SRAM data/address widths, the default frame
//           start marker and the loader FSM state type.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package spm_boot_pkg;

  localparam int         c_word_size = 8;      // SRAM data width / rx byte width
  localparam int         c_addr_size = 8;      // SRAM address width
  localparam logic [7:0] c_sync_byte = 8'hA5;  // default frame start marker

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_CLEAR = 4'd1,
    ST_SYNC  = 4'd2,
    ST_ADDR  = 4'd3,
    ST_LEN   = 4'd4,
    ST_DATA  = 4'd5,
    ST_CSUM  = 4'd6,
    ST_DONE  = 4'd7,
    ST_ERR   = 4'd8
  } boot_state_e;

endpackage : spm_boot_pkg
`default_nettype wire

// File: rtl/spm_boot_loader.sv
`default_nettype none
// ============================================================================
// Module  : spm_boot_loader
// Purpose : Upstream program loader for the RISC_SPM core. Accepts a framed
//           byte stream (SYNC, ADDR, LEN, LEN data bytes, CSUM), optionally
//           zero-fills the SRAM first, writes the image through the SRAM
//           write port and releases the core (cpu_hold=0) only after a frame
//           whose mod-2^word_size sum of ADDR+LEN+data+CSUM is zero.
//           At system level cpu_hold selects this port (1) or the core (0)
//           onto the SRAM write port.
// Ports   : clk, rst (sync, active-high), start (1-cycle boot request)
//           rx_data/rx_valid/rx_ready  : byte stream, transfer on valid&ready
//           mem_addr/mem_wdata/mem_we  : SRAM write port
//           cpu_hold                   : 1 holds the core in reset
//           busy/done/err              : status levels
//           words_loaded               : data bytes written in current frame
// Revision: 1.0 - initial release
// ============================================================================
module spm_boot_loader
  import spm_boot_pkg::*;
#(
  parameter int                   word_size     = c_word_size,
  parameter int                   addr_size     = c_addr_size,
  parameter logic [word_size-1:0] SYNC_BYTE     = word_size'(c_sync_byte),
  parameter bit                   CLEAR_ON_BOOT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [word_size-1:0] rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic [addr_size-1:0] mem_addr,
  output logic [word_size-1:0] mem_wdata,
  output logic                 mem_we,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [addr_size:0]   words_loaded
);

  localparam logic [addr_size-1:0] c_clr_last = '1;
  localparam logic [addr_size:0]   c_wl_max   = {1'b1, {addr_size{1'b0}}};
  localparam logic [word_size-1:0] c_len_one  = word_size'(1);

  boot_state_e          state, state_nxt;
  logic [addr_size-1:0] clr_cnt;
  logic [addr_size-1:0] ptr;
  logic [word_size-1:0] len_cnt;
  logic [word_size-1:0] sum;
  logic                 wr_we;
  logic [addr_size-1:0] wr_addr;
  logic [word_size-1:0] wr_data;

  logic                 accept;
  logic [word_size-1:0] sum_nxt;

  assign accept  = rx_valid & rx_ready;
  assign sum_nxt = sum + rx_data;

  // --------------------------------------------------------------------------
  // Next-state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    cpu_hold  = 1'b1;
    // The clear sweep drives the port directly; data writes come from the
    // registered one-cycle-late copy of the accepted byte.
    mem_we    = wr_we;
    mem_addr  = wr_addr;
    mem_wdata = wr_data;

    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        done     = (state == ST_DONE);
        err      = (state == ST_ERR);
        cpu_hold = (state != ST_DONE);
        if (start) state_nxt = CLEAR_ON_BOOT ? ST_CLEAR : ST_SYNC;
      end
      ST_CLEAR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = clr_cnt;
        mem_wdata = '0;
        if (clr_cnt == c_clr_last) state_nxt = ST_SYNC;
      end
      ST_SYNC: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (accept && (rx_data == SYNC_BYTE)) state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (accept) state_nxt = ST_LEN;
      end
      ST_LEN: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (accept) state_nxt = (rx_data == '0) ? ST_CSUM : ST_DATA;
      end
      ST_DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (accept && (len_cnt == c_len_one)) state_nxt = ST_CSUM;
      end
      ST_CSUM: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (accept) state_nxt = (sum_nxt == '0) ? ST_DONE : ST_ERR;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State register and datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      clr_cnt      <= '0;
      ptr          <= '0;
      len_cnt      <= '0;
      sum          <= '0;
      wr_we        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      words_loaded <= '0;
    end else begin
      state <= state_nxt;
      wr_we <= 1'b0;

      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            words_loaded <= '0;
            clr_cnt      <= '0;
          end
        end
        ST_CLEAR: clr_cnt <= clr_cnt + 1'b1;
        ST_ADDR: begin
          if (accept) begin
            ptr <= addr_size'(rx_data);
            sum <= rx_data;
          end
        end
        ST_LEN: begin
          if (accept) begin
            len_cnt <= rx_data;
            sum     <= sum_nxt;
          end
        end
        ST_DATA: begin
          if (accept) begin
            wr_we   <= 1'b1;
            wr_addr <= ptr;
            wr_data <= rx_data;
            ptr     <= ptr + 1'b1;
            sum     <= sum_nxt;
            len_cnt <= len_cnt - 1'b1;
            if (words_loaded != c_wl_max) words_loaded <= words_loaded + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : spm_boot_loader
`default_nettype wire

// File: tb/tb_spm_boot_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_spm_boot_loader
// Purpose : Self-checking bench for spm_boot_loader. Drives framed byte
//           streams (directed and $urandom-generated) and compares the SRAM
//           image, status levels, write counts and timing against a
//           frame-level reference model kept in the bench.
// Ports   : none (top-level bench)
// Revision: 1.0 - initial release
// ============================================================================
module tb_spm_boot_loader;
  import spm_boot_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       err;
  logic [8:0] words_loaded;

  spm_boot_loader #(
    .word_size    (8),
    .addr_size    (8),
    .SYNC_BYTE    (8'hA5),
    .CLEAR_ON_BOOT(1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .cpu_hold    (cpu_hold),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // SRAM model and write log
  // --------------------------------------------------------------------------
  logic [7:0] sram    [256];
  logic [7:0] exp_mem [256];
  logic       preset_en = 1'b0;
  int         we_total = 0;
  int         cyc = 0;
  logic [7:0] wlog_addr[$];
  logic [7:0] wlog_data[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      sram[mem_addr] <= mem_wdata;
      we_total       <= we_total + 1;
      wlog_addr.push_back(mem_addr);
      wlog_data.push_back(mem_wdata);
    end else if (preset_en) begin
      foreach (sram[i]) sram[i] <= 8'h55;
    end
  end

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int vectors     = 0;
  int miscompares = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < 256; i++) if (sram[i] !== exp_mem[i]) n++;
    return n;
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus helpers (all called and returning at a negedge)
  // --------------------------------------------------------------------------
  logic [7:0] frame_data[$];
  logic [7:0] garbage_q[$];

  task automatic send_byte(input logic [7:0] b, input int stall_pct);
    int  n;
    bit  ok;
    if (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(3, 1)) @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      ok = rx_ready;
      @(posedge clk);
      n++;
      if (!ok) @(negedge clk);
    end
    if (!ok) check_value("rx_accept_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic start_and_wait_sync(input bit chk_clear, input bit poke_start);
    int base;
    int n;
    int bad;
    base  = we_total;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!rx_ready && n < 400) begin
      // a start pulse in the middle of the sweep must not restart it
      start = (poke_start && n == 20);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check_value("sync_reached", rx_ready, 1);
    foreach (exp_mem[i]) exp_mem[i] = 8'h00;
    if (chk_clear) begin
      check_value("clear_we_count", we_total - base, 256);
      bad = 0;
      for (int i = 0; i < 256; i++)
        if (base + i >= wlog_addr.size() || wlog_addr[base+i] != 8'(i) || wlog_data[base+i] != 8'h00) bad++;
      check_value("clear_sequence", bad, 0);
      check_value("clear_image", mem_diffs(), 0);
    end
    check_value("busy_in_sync", busy, 1);
    check_value("hold_in_sync", cpu_hold, 1);
    check_value("wl_cleared", words_loaded, 0);
  endtask

  // Full boot: frame built from frame_data/garbage_q, expectations from the
  // frame-level rule: image lands at (addr+i) mod 256, frame good when the
  // byte sum of ADDR, LEN, data and CSUM is 0 mod 256.
  task automatic do_boot(input logic [7:0] addr, input bit corrupt, input int stall_pct,
                         input bit chk_clear, input bit poke_start);
    int         len;
    int         s;
    int         t0;
    int         wb;
    logic [7:0] csum;
    bit         good;
    len = frame_data.size();
    start_and_wait_sync(chk_clear, poke_start);
    t0 = cyc;
    wb = we_total;
    s  = addr + len;
    foreach (frame_data[i]) s += frame_data[i];
    csum = 8'((256 - (s % 256)) % 256);
    if (corrupt) csum = csum + 8'd1;
    good = ((s + csum) % 256) == 0;
    foreach (garbage_q[i]) send_byte(garbage_q[i], stall_pct);
    send_byte(8'hA5, stall_pct);
    send_byte(addr, stall_pct);
    send_byte(8'(len), stall_pct);
    foreach (frame_data[i]) send_byte(frame_data[i], stall_pct);
    send_byte(csum, stall_pct);
    if (stall_pct == 0 && garbage_q.size() == 0)
      check_value("b2b_cycles", cyc - t0, len + 4);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < len; i++) exp_mem[(addr + i) % 256] = frame_data[i];
    check_value("done", done, good);
    check_value("err", err, !good);
    check_value("cpu_hold", cpu_hold, !good);
    check_value("words_loaded", words_loaded, len);
    check_value("busy_after", busy, 0);
    check_value("ready_after", rx_ready, 0);
    check_value("frame_we_count", we_total - wb, len);
    check_value("frame_image", mem_diffs(), 0);
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    logic [7:0] a;
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    preset_en = 1'b1;
    repeat (3) @(negedge clk);
    preset_en = 1'b0;

    // reset state
    check_value("rst_rx_ready", rx_ready, 0);
    check_value("rst_mem_we", mem_we, 0);
    check_value("rst_mem_addr", mem_addr, 0);
    check_value("rst_mem_wdata", mem_wdata, 0);
    check_value("rst_busy", busy, 0);
    check_value("rst_done", done, 0);
    check_value("rst_err", err, 0);
    check_value("rst_words", words_loaded, 0);
    check_value("rst_hold", cpu_hold, 1);
    rst = 1'b0;
    @(negedge clk);
    check_value("idle_hold", cpu_hold, 1);
    check_value("idle_we", mem_we, 0);

    // clear sweep over a 0x55 image, then the reference frame
    frame_data = '{8'hA0, 8'h45, 8'hA1, 8'h59};
    garbage_q  = {};
    do_boot(8'h01, 1'b0, 0, 1'b1, 1'b1);

    // same frame, bad checksum: data still written
    do_boot(8'h01, 1'b1, 0, 1'b1, 1'b0);

    // leading garbage discarded, address wraps FE, FF, 00
    frame_data = '{8'h11, 8'h22, 8'h33};
    garbage_q  = '{8'h00, 8'h7F};
    do_boot(8'hFE, 1'b0, 0, 1'b0, 1'b0);

    // rx_valid gaps during the frame
    frame_data = {};
    for (int i = 0; i < 8; i++) frame_data.push_back(8'($urandom));
    garbage_q  = {};
    do_boot(8'h40, 1'b0, 60, 1'b0, 1'b0);

    // zero-length frame
    frame_data = {};
    do_boot(8'h80, 1'b0, 0, 1'b0, 1'b0);

    // reset in the middle of DATA after 2 of 4 bytes
    start_and_wait_sync(1'b0, 1'b0);
    a = 8'h10;
    send_byte(8'hA5, 0);
    send_byte(a, 0);
    send_byte(8'd4, 0);
    send_byte(8'hC1, 0);
    send_byte(8'hC2, 0);
    rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_mem[a]      = 8'hC1;
    exp_mem[a + 1]  = 8'hC2;
    check_value("abort_ready", rx_ready, 0);
    check_value("abort_we", mem_we, 0);
    check_value("abort_hold", cpu_hold, 1);
    check_value("abort_busy", busy, 0);
    check_value("abort_words", words_loaded, 0);
    check_value("abort_image", mem_diffs(), 0);
    repeat (3) @(negedge clk);
    check_value("abort_stays_idle", busy, 0);
    frame_data = '{8'h01, 8'h02, 8'h03, 8'h04};
    do_boot(8'h10, 1'b0, 0, 1'b0, 1'b0);

    // randomized frames
    for (int k = 0; k < 6; k++) begin
      int len;
      len = $urandom_range(12, 0);
      frame_data = {};
      for (int i = 0; i < len; i++) frame_data.push_back(8'($urandom));
      garbage_q = {};
      for (int i = 0; i < int'($urandom_range(3, 0)); i++) begin
        logic [7:0] g;
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        garbage_q.push_back(g);
      end
      do_boot(8'($urandom), $urandom_range(3, 0) == 0, ($urandom_range(1, 0) != 0) ? 30 : 0,
              1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule : tb_spm_boot_loader
`default_nettype wire
